// File: rtl/comparator_seq_nbit.sv
// Sequential magnitude comparator. Operands are compared one DIGIT-wide
// slice per clock, starting at the most-significant slice. The compare stops
// at the first slice that differs. Signed mode flips the sign bit of both
// operands at capture, so the datapath itself only ever compares unsigned
// values.

// Per-digit unsigned compare. One instance exists for each digit position.
module cmp_digit #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         lt
);
    assign gt = (a > b);
    assign lt = (a < b);
endmodule

module comparator_seq_nbit #(
    parameter int WIDTH = 16,   // must be >= 2 and a multiple of DIGIT
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_greater_B,
    output logic             A_less_B,
    output logic             A_equal_B
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    // Flipping the MSB maps two's-complement ordering onto unsigned ordering.
    localparam logic [WIDTH-1:0] SIGN_MSK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, a_nx;
    logic [WIDTH-1:0] b_q, b_nx;
    logic [IDX_W-1:0] idx_q, idx_nx;
    logic             gt_q, gt_nx;
    logic             lt_q, lt_nx;
    logic             eq_q, eq_nx;

    // Captured operands viewed as an array of digits.
    logic [NDIG-1:0][DIGIT-1:0] a_dig, b_dig;
    logic [NDIG-1:0]            gt_vec, lt_vec;
    logic                       gt_sel, lt_sel;

    assign a_dig = a_q;
    assign b_dig = b_q;

    // All digit positions are compared in parallel; idx picks the live one.
    // This keeps the per-cycle path to a single DIGIT-wide compare plus a mux.
    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        cmp_digit #(.W(DIGIT)) u_dig (
            .a  (a_dig[g]),
            .b  (b_dig[g]),
            .gt (gt_vec[g]),
            .lt (lt_vec[g])
        );
    end

    assign gt_sel = gt_vec[idx_q];
    assign lt_sel = lt_vec[idx_q];

    // State, operand, index and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            idx_q <= '0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
            eq_q  <= 1'b0;
        end else begin
            state <= state_nx;
            a_q   <= a_nx;
            b_q   <= b_nx;
            idx_q <= idx_nx;
            gt_q  <= gt_nx;
            lt_q  <= lt_nx;
            eq_q  <= eq_nx;
        end
    end

    // Next-state and datapath update. Everything holds by default; start is
    // only looked at in IDLE, so requests during COMPARE/DONE are dropped.
    always_comb begin
        state_nx = state;
        a_nx     = a_q;
        b_nx     = b_q;
        idx_nx   = idx_q;
        gt_nx    = gt_q;
        lt_nx    = lt_q;
        eq_nx    = eq_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    a_nx     = is_signed ? (A ^ SIGN_MSK) : A;
                    b_nx     = is_signed ? (B ^ SIGN_MSK) : B;
                    idx_nx   = IDX_TOP;
                    gt_nx    = 1'b0;
                    lt_nx    = 1'b0;
                    eq_nx    = 1'b0;
                    state_nx = COMPARE;
                end
            end
            COMPARE: begin
                if (gt_sel) begin
                    gt_nx    = 1'b1;
                    state_nx = DONE;
                end else if (lt_sel) begin
                    lt_nx    = 1'b1;
                    state_nx = DONE;
                end else if (idx_q == '0) begin
                    eq_nx    = 1'b1;
                    state_nx = DONE;
                end else begin
                    idx_nx   = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy        = (state == COMPARE);
    assign done        = (state == DONE);
    assign A_greater_B = gt_q;
    assign A_less_B    = lt_q;
    assign A_equal_B   = eq_q;

endmodule
